// File: rtl/mux421_chk.sv
// mux421_chk: run-based checker for a 4:1 mux under test.
// Valid samples taken while a run is active are turned into an expected value,
// delayed by LATENCY cycles to line up with MuxOut, and compared there.
// The checker counts comparisons and mismatches, pulses Error once per mismatch,
// and reports Done/Pass when the run has fully drained.
module mux421_chk #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In0,
  input  logic             In1,
  input  logic             In2,
  input  logic             In3,
  input  logic             Sel0,
  input  logic             Sel1,
  input  logic             MuxOut,
  input  logic             Valid,
  input  logic             Start,
  input  logic             Stop,
  output logic             Error,
  output logic [CNT_W-1:0] CheckCount,
  output logic [CNT_W-1:0] ErrCount,
  output logic             Done,
  output logic             Pass
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int              PIPE_D     = (LATENCY > 0) ? LATENCY : 1;
  localparam logic [1:0]      DRAIN_LAST = 2'((LATENCY > 0) ? (LATENCY - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state;
  state_t     state_next;
  logic [1:0] drain_cnt;
  logic [1:0] drain_cnt_next;
  logic       clear_cnt;
  logic       accept;
  logic [3:0] in_vec;
  logic       exp_now;
  logic       cmp_v;
  logic       cmp_exp;
  logic       mismatch;

  assign in_vec  = {In3, In2, In1, In0};
  assign exp_now = in_vec[{Sel1, Sel0}];
  assign accept  = (state == RUN) && Valid;

  // State register and drain-cycle counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      drain_cnt <= 2'd0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  // Run control: Start opens a run from IDLE/DONE, Stop closes it, DRAIN flushes the pipeline
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    clear_cnt      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_next = RUN;
          clear_cnt  = 1'b1;
        end
      end
      RUN: begin
        if (Stop) begin
          drain_cnt_next = 2'd0;
          if (LATENCY == 0) state_next = DONE;
          else              state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_next = DONE;
        else                         drain_cnt_next = drain_cnt + 2'd1;
      end
      DONE: begin
        if (Start) begin
          state_next = RUN;
          clear_cnt  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Expected value and accept flag travel together so the compare lines up with MuxOut
  if (LATENCY == 0) begin : g_nopipe
    assign cmp_v   = accept;
    assign cmp_exp = exp_now;
  end else begin : g_pipe
    logic [PIPE_D-1:0] pipe_v;
    logic [PIPE_D-1:0] pipe_e;

    // Shift register of in-flight samples; reset discards everything in flight
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        pipe_v <= '0;
        pipe_e <= '0;
      end else begin
        pipe_v[0] <= accept;
        pipe_e[0] <= exp_now;
        for (int i = 1; i < PIPE_D; i++) begin
          pipe_v[i] <= pipe_v[i-1];
          pipe_e[i] <= pipe_e[i-1];
        end
      end
    end

    assign cmp_v   = pipe_v[PIPE_D-1];
    assign cmp_exp = pipe_e[PIPE_D-1];
  end

  // Case inequality so an X or Z on MuxOut is reported as a mismatch
  assign mismatch = cmp_v && (MuxOut !== cmp_exp);

  // Saturating comparison and mismatch counters, cleared when a run starts
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      CheckCount <= '0;
      ErrCount   <= '0;
    end else if (clear_cnt) begin
      CheckCount <= '0;
      ErrCount   <= '0;
    end else if (cmp_v) begin
      if (CheckCount != CNT_MAX) CheckCount <= CheckCount + CNT_W'(1);
      if (mismatch && (ErrCount != CNT_MAX)) ErrCount <= ErrCount + CNT_W'(1);
    end
  end

  // One-cycle Error pulse in the cycle after each failing compare
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) Error <= 1'b0;
    else       Error <= mismatch;
  end

  assign Done = (state == DONE);
  assign Pass = Done && (ErrCount == '0) && (CheckCount != '0);

endmodule
